// File: rtl/dmem_pkg.sv
// Shared types for the data-memory responder.
//  dm_ctrl_t     : funct3 access encoding (loads, with store aliases)
//  state_t       : responder FSM states
//  is_legal_ctrl : 1 when ctrl is a legal access code for the given direction
package dmem_pkg;

   typedef enum logic [2:0] {
      DM_LB  = 3'b000,
      DM_LH  = 3'b001,
      DM_LW  = 3'b010,
      DM_LBU = 3'b100,
      DM_LHU = 3'b101
   } dm_ctrl_t;

   localparam dm_ctrl_t DM_SB = DM_LB;
   localparam dm_ctrl_t DM_SH = DM_LH;
   localparam dm_ctrl_t DM_SW = DM_LW;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam int CNT_W = 4;

   // Unsigned variants only make sense for loads.
   function automatic logic is_legal_ctrl(input logic [2:0] ctrl, input logic write);
      logic ok;
      case (ctrl)
         3'b000, 3'b001, 3'b010: ok = 1'b1;
         3'b100, 3'b101:         ok = ~write;
         default:                ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane steering for the data-memory responder.
//  word_in    : 32-bit word currently held at the addressed location
//  addr_lo    : byte offset within the word
//  ctrl       : funct3 access code
//  wdata      : store data (low byte/half/word used)
//  load_data  : selected lane, sign- or zero-extended
//  store_word : word_in with the addressed lanes replaced by store data
//  byte_en    : lanes touched by the access
//  misaligned : half on odd address or word not on a 4-byte boundary
module dmem_lane_align (
   input  logic [31:0] word_in,
   input  logic [1:0]  addr_lo,
   input  logic [2:0]  ctrl,
   input  logic [31:0] wdata,
   output logic [31:0] load_data,
   output logic [31:0] store_word,
   output logic [3:0]  byte_en,
   output logic        misaligned
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;
   logic [31:0] wdata_rep;

   always_comb begin
      case (addr_lo)
         2'd0:    byte_sel = word_in[7:0];
         2'd1:    byte_sel = word_in[15:8];
         2'd2:    byte_sel = word_in[23:16];
         default: byte_sel = word_in[31:24];
      endcase
      half_sel = addr_lo[1] ? word_in[31:16] : word_in[15:0];
   end

   // ctrl[2] selects zero extension; ctrl[1:0] gives the access size.
   always_comb begin
      load_data  = '0;
      byte_en    = '0;
      wdata_rep  = '0;
      misaligned = 1'b0;
      case (ctrl[1:0])
         2'b00: begin
            byte_en   = 4'b0001 << addr_lo;
            wdata_rep = {4{wdata[7:0]}};
            load_data = ctrl[2] ? {24'b0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
         end
         2'b01: begin
            byte_en    = addr_lo[1] ? 4'b1100 : 4'b0011;
            wdata_rep  = {2{wdata[15:0]}};
            load_data  = ctrl[2] ? {16'b0, half_sel} : {{16{half_sel[15]}}, half_sel};
            misaligned = addr_lo[0];
         end
         2'b10: begin
            byte_en    = 4'b1111;
            wdata_rep  = wdata;
            load_data  = word_in;
            misaligned = (addr_lo != 2'b00);
         end
         default: ;
      endcase
   end

   always_comb begin
      store_word = word_in;
      for (int i = 0; i < 4; i++) begin
         if (byte_en[i]) store_word[8*i +: 8] = wdata_rep[8*i +: 8];
      end
   end

endmodule

// File: rtl/dmem_responder.sv
// Memory-side responder for the core's data-memory port. One request at a
// time is accepted, held for a programmable latency, executed against local
// storage, and answered over a second valid/ready handshake.
//  clk, reset          : clock, asynchronous active-low reset
//  req_valid/req_ready : request handshake
//  req_write, req_addr, req_wdata, req_ctrl : request payload
//  rsp_valid/rsp_ready : response handshake
//  rsp_rdata, rsp_err  : load result (0 for stores/errors), error flag
//
//  state | meaning
//  ------+-------------------------------------------------------------
//  IDLE  | ready for a request
//  WAIT  | request latched; fetch addressed word, then count down
//  RESP  | response registered, held until rsp_ready
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int DEPTH_WORDS = 1024,
   parameter int LATENCY     = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [2:0]  req_ctrl,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err
);

   localparam int          IDX_W      = $clog2(DEPTH_WORDS);
   localparam logic [31:0] ADDR_LIMIT = 32'(4 * DEPTH_WORDS);

   state_t             state, state_nxt;
   logic [CNT_W-1:0]   cnt;
   logic               fetched;
   logic               wr_q;
   logic [31:0]        addr_q;
   logic [31:0]        wdata_q;
   logic [2:0]         ctrl_q;
   logic [31:0]        word_q;
   logic [31:0]        mem [DEPTH_WORDS];

   logic               accept;
   logic               eval;
   logic               rd_en;
   logic               mem_we;
   logic               err;
   logic [IDX_W-1:0]   idx;
   logic [31:0]        load_data;
   logic [31:0]        store_word;
   logic [3:0]         byte_en;
   logic               misaligned;

   assign accept = req_valid & req_ready;
   assign idx    = addr_q[IDX_W+1:2];

   // The first WAIT cycle reads storage into word_q so the array maps onto a
   // synchronous-read RAM; the countdown runs after that, which gives the
   // LATENCY+1 edges from accept to rsp_valid.
   assign rd_en  = (state == WAIT) & ~fetched;
   assign eval   = (state == WAIT) & fetched & (cnt == '0);

   assign err    = misaligned | (addr_q >= ADDR_LIMIT) | ~is_legal_ctrl(ctrl_q, wr_q);
   assign mem_we = eval & wr_q & ~err;

   dmem_lane_align u_align (
      .word_in    (word_q),
      .addr_lo    (addr_q[1:0]),
      .ctrl       (ctrl_q),
      .wdata      (wdata_q),
      .load_data  (load_data),
      .store_word (store_word),
      .byte_en    (byte_en),
      .misaligned (misaligned)
   );

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept)    state_nxt = WAIT;
         WAIT:    if (eval)      state_nxt = RESP;
         RESP:    if (rsp_ready) state_nxt = IDLE;
         default:                state_nxt = IDLE;
      endcase
   end

   // Output logic
   always_comb begin
      req_ready = 1'b0;
      rsp_valid = 1'b0;
      case (state)
         IDLE:    req_ready = 1'b1;
         RESP:    rsp_valid = 1'b1;
         default: ;
      endcase
   end

   // Request latch, countdown and response registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt       <= '0;
         fetched   <= 1'b0;
         wr_q      <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         ctrl_q    <= '0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
      end else if (accept) begin
         cnt     <= CNT_W'(LATENCY - 1);
         fetched <= 1'b0;
         wr_q    <= req_write;
         addr_q  <= req_addr;
         wdata_q <= req_wdata;
         ctrl_q  <= req_ctrl;
      end else if (state == WAIT) begin
         if (!fetched) begin
            fetched <= 1'b1;
         end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
         end else begin
            rsp_err   <= err;
            rsp_rdata <= (err | wr_q) ? 32'h0 : load_data;
         end
      end
   end

   // Storage is deliberately not reset.
   always_ff @(posedge clk) begin
      if (mem_we) mem[idx] <= store_word;
      if (rd_en)  word_q   <= mem[idx];
   end

   logic unused_ok;
   assign unused_ok = ^byte_en;

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [2:0]  req_ctrl;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_err;

   int n_pass = 0;
   int n_total = 0;

   dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(2)) dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_write (req_write),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .req_ctrl  (req_ctrl),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        write;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [2:0]  ctrl;
      logic [31:0] exp_rdata;
      logic        exp_err;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic w, input logic [31:0] a, input logic [31:0] d,
                               input logic [2:0] c, input logic [31:0] er, input logic ee);
      vec_t v;
      v.write = w; v.addr = a; v.wdata = d; v.ctrl = c; v.exp_rdata = er; v.exp_err = ee;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
   endtask

   // All tasks are entered #1 after a rising edge and return at the same phase.
   task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [2:0] c);
      req_write = w; req_addr = a; req_wdata = d; req_ctrl = c; req_valid = 1'b1;
   endtask

   task automatic wait_accept(input string name);
      logic rr;
      int   n;
      n = 0;
      forever begin
         rr = req_ready;
         @(posedge clk); #1;
         if (rr) break;
         n++;
         if (n > 50) begin
            chk({name, " accept timeout"}, 32'(n), 32'd0);
            break;
         end
      end
      req_valid = 1'b0;
   endtask

   task automatic wait_rsp(output int edges);
      edges = 0;
      do begin
         @(posedge clk); #1;
         edges++;
      end while (!rsp_valid && edges < 50);
   endtask

   task automatic finish_rsp(input string name);
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      chk({name, " rsp_valid drop"}, 32'(rsp_valid), 32'd0);
   endtask

   task automatic run_vec(input string name, input vec_t v);
      int edges;
      issue(v.write, v.addr, v.wdata, v.ctrl);
      wait_accept(name);
      wait_rsp(edges);
      chk({name, " latency"}, 32'(edges), 32'd3);
      chk({name, " rdata"}, rsp_rdata, v.exp_rdata);
      chk({name, " err"}, 32'(rsp_err), 32'(v.exp_err));
      finish_rsp(name);
   endtask

   initial begin
      #200000;
      $display("FAIL global timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      int edges;
      logic [31:0] held;

      reset = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
      req_wdata = '0; req_ctrl = '0; rsp_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset req_ready", 32'(req_ready), 32'd1);
      chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
      chk("reset rsp_rdata", rsp_rdata, 32'd0);
      chk("reset rsp_err", 32'(rsp_err), 32'd0);
      reset = 1'b1;
      @(posedge clk); #1;

      //            w     addr        wdata         ctrl    exp_rdata     err
      vecs.push_back(mk(1, 32'h10,  32'hDEADBEEF, 3'b010, 32'h0,        0));
      vecs.push_back(mk(0, 32'h10,  32'h0,        3'b010, 32'hDEADBEEF, 0));
      vecs.push_back(mk(0, 32'h11,  32'h0,        3'b000, 32'hFFFFFFBE, 0));
      vecs.push_back(mk(0, 32'h11,  32'h0,        3'b100, 32'h000000BE, 0));
      vecs.push_back(mk(0, 32'h12,  32'h0,        3'b001, 32'hFFFFDEAD, 0));
      vecs.push_back(mk(0, 32'h10,  32'h0,        3'b101, 32'h0000BEEF, 0));
      vecs.push_back(mk(1, 32'h13,  32'h00000012, 3'b000, 32'h0,        0));
      vecs.push_back(mk(0, 32'h10,  32'h0,        3'b010, 32'h12ADBEEF, 0));
      vecs.push_back(mk(1, 32'h0C,  32'h01234567, 3'b010, 32'h0,        0));
      vecs.push_back(mk(1, 32'h0E,  32'hFFFFFFFF, 3'b010, 32'h0,        1));
      vecs.push_back(mk(0, 32'h0C,  32'h0,        3'b010, 32'h01234567, 0));
      vecs.push_back(mk(1, 32'hFFC, 32'hCAFEF00D, 3'b010, 32'h0,        0));
      vecs.push_back(mk(0, 32'hFFC, 32'h0,        3'b010, 32'hCAFEF00D, 0));
      vecs.push_back(mk(0, 32'h1000,32'h0,        3'b010, 32'h0,        1));
      vecs.push_back(mk(0, 32'h10,  32'h0,        3'b011, 32'h0,        1));
      vecs.push_back(mk(1, 32'h10,  32'h00000077, 3'b100, 32'h0,        1));
      vecs.push_back(mk(0, 32'h10,  32'h0,        3'b010, 32'h12ADBEEF, 0));
      vecs.push_back(mk(0, 32'h11,  32'h0,        3'b001, 32'h0,        1));
      vecs.push_back(mk(0, 32'h12,  32'h0,        3'b101, 32'h000012AD, 0));
      vecs.push_back(mk(0, 32'h13,  32'h0,        3'b000, 32'h00000012, 0));
      vecs.push_back(mk(1, 32'h12,  32'hFFFF8001, 3'b001, 32'h0,        0));
      vecs.push_back(mk(0, 32'h10,  32'h0,        3'b010, 32'h8001BEEF, 0));
      vecs.push_back(mk(0, 32'h12,  32'h0,        3'b001, 32'hFFFF8001, 0));
      vecs.push_back(mk(1, 32'h20,  32'h11111111, 3'b010, 32'h0,        0));

      for (int i = 0; i < vecs.size(); i++) begin
         run_vec($sformatf("vec%0d", i), vecs[i]);
      end

      // Backpressure: response held 5 cycles while a second request waits.
      issue(0, 32'h10, 32'h0, 3'b010);
      wait_accept("bp");
      wait_rsp(edges);
      chk("bp latency", 32'(edges), 32'd3);
      held = rsp_rdata;
      chk("bp rdata", held, 32'h8001BEEF);
      issue(0, 32'hFFC, 32'h0, 3'b010);
      for (int k = 0; k < 5; k++) begin
         @(posedge clk); #1;
         chk($sformatf("bp hold%0d valid", k), 32'(rsp_valid), 32'd1);
         chk($sformatf("bp hold%0d rdata", k), rsp_rdata, 32'h8001BEEF);
         chk($sformatf("bp hold%0d req_ready", k), 32'(req_ready), 32'd0);
      end
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      chk("bp after hs valid", 32'(rsp_valid), 32'd0);
      chk("bp after hs req_ready", 32'(req_ready), 32'd1);
      @(posedge clk); #1;
      req_valid = 1'b0;
      chk("bp queued accepted", 32'(req_ready), 32'd0);
      wait_rsp(edges);
      chk("bp2 latency", 32'(edges), 32'd3);
      chk("bp2 rdata", rsp_rdata, 32'hCAFEF00D);
      chk("bp2 err", 32'(rsp_err), 32'd0);
      finish_rsp("bp2");

      // Mid-operation reset aborts an uncommitted store.
      issue(1, 32'h20, 32'h55AA55AA, 3'b010);
      wait_accept("mid");
      @(posedge clk); #1;
      reset = 1'b0;
      #1;
      chk("mid req_ready", 32'(req_ready), 32'd1);
      chk("mid rsp_valid", 32'(rsp_valid), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk); #1;
      run_vec("mid reload", mk(0, 32'h20, 32'h0, 3'b010, 32'h11111111, 0));

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
